xor_decoder_stream: RTL and testbench



---
 rtl/xordec_pkg.sv | 19 +
 rtl/xordec_fifo2.sv | 65 ++++++
 rtl/xor_decoder_stream.sv | 87 ++++++++
 tb/tb_xor_decoder_stream.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/xordec_pkg.sv
// Shared types for the xor decoder stream: request modes and result-buffer occupancy.
package xordec_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    STRIPE = 2'd0,
    ONEHOT = 2'd1,
    THERM  = 2'd2,
    XACC   = 2'd3
  } xordec_mode_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } xordec_occ_t;

endpackage

// File: rtl/xordec_fifo2.sv
// Two-entry result buffer. The head register drives out_data; ready/valid come
// only from registered occupancy, so there is no out_ready -> in_ready path.
module xordec_fifo2
  import xordec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  xordec_occ_t  occ;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         push;
  logic         pop;

  assign in_ready  = (occ != OCC_FULL);
  assign out_valid = (occ != OCC_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_ready & out_valid;
  assign out_data  = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset as well, because out must read 0 after reset.
      occ  <= OCC_EMPTY;
      head <= '0;
      tail <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head <= in_data;
            occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          // Simultaneous push and pop: the new entry replaces the head directly.
          if (push && pop) begin
            head <= in_data;
          end else if (push) begin
            tail <= in_data;
            occ  <= OCC_FULL;
          end else if (pop) begin
            occ  <= OCC_EMPTY;
          end
        end
        default: begin
          if (pop) begin
            head <= tail;
            occ  <= OCC_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/xor_decoder_stream.sv
// Expands a select word into an OUT_W-bit pattern (stripe, one-hot, thermometer
// or accumulated stripe) and delivers results through a 2-entry buffer.
module xor_decoder_stream
  import xordec_pkg::*;
#(
  parameter int SEL_W = 1,
  parameter int OUT_W = 128,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  a,
  input  logic [MODE_W-1:0] mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out,
  output logic [CNT_W-1:0]  accepted
);

  function automatic logic [OUT_W-1:0] stripe_pat(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] p;
    p = '0;
    for (int i = 0; i < OUT_W; i += 2) p[i] = sel[(i / 2) % SEL_W];
    return p;
  endfunction

  function automatic logic [OUT_W-1:0] onehot_pat(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] p;
    for (int i = 0; i < OUT_W; i++) p[i] = (i == int'(sel));
    return p;
  endfunction

  function automatic logic [OUT_W-1:0] therm_pat(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] p;
    for (int i = 0; i < OUT_W; i++) p[i] = (i < int'(sel));
    return p;
  endfunction

  xordec_mode_t     mode_e;
  logic             accept;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_next;
  logic [OUT_W-1:0] stripe_p;
  logic [OUT_W-1:0] result;

  assign mode_e = xordec_mode_t'(mode);
  assign accept = in_valid & in_ready;

  always_comb begin
    // NOTE: result gets a default first so no path through the case can infer a latch.
    result   = '0;
    stripe_p = stripe_pat(a);
    acc_next = acc ^ stripe_p;
    case (mode_e)
      STRIPE:  result = stripe_p;
      ONEHOT:  result = onehot_pat(a);
      THERM:   result = therm_pat(a);
      default: result = acc_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      accepted <= '0;
    end else if (accept) begin
      accepted <= accepted + CNT_W'(1);
      if (mode_e == XACC) acc <= acc_next;
    end
  end

  xordec_fifo2 #(
    .W(OUT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out)
  );

endmodule

// File: tb/tb_xor_decoder_stream.sv
// Drives a SEL_W=1 and a SEL_W=8 instance in lockstep and compares both against
// a queue-based model built directly from the pattern definitions.
module tb_xor_decoder_stream;
  import xordec_pkg::*;

  localparam int OUT_W = 128;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             out_ready;
  logic [1:0]       mode;
  logic [7:0]       a8;
  logic [0:0]       a1;
  logic             in_ready1, out_valid1, in_ready8, out_valid8;
  logic [OUT_W-1:0] out1, out8;
  logic [CNT_W-1:0] accepted1, accepted8;

  int               checks = 0;
  int               failures = 0;
  logic [OUT_W-1:0] q1[$];
  logic [OUT_W-1:0] q8[$];
  logic [OUT_W-1:0] acc1, acc8;
  int               n_acc;

  always #5 clk = ~clk;

  xor_decoder_stream #(.SEL_W(1), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a1), .mode(mode),
    .out_valid(out_valid1), .out_ready(out_ready), .out(out1), .accepted(accepted1)
  );

  xor_decoder_stream #(.SEL_W(8), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .a(a8), .mode(mode),
    .out_valid(out_valid8), .out_ready(out_ready), .out(out8), .accepted(accepted8)
  );

  // Pattern for a select value, straight from the mode definitions.
  function automatic logic [OUT_W-1:0] model_pat(int selw, int m, int av, logic [OUT_W-1:0] acc);
    logic [OUT_W-1:0] s;
    logic [OUT_W-1:0] p;
    s = '0;
    p = '0;
    for (int i = 0; i < OUT_W; i++)
      s[i] = (i % 2 == 0) && (((av >> ((i / 2) % selw)) & 1) == 1);
    case (m)
      0: p = s;
      1: for (int i = 0; i < OUT_W; i++) p[i] = (i == av);
      2: for (int i = 0; i < OUT_W; i++) p[i] = (i < av);
      default: p = acc ^ s;
    endcase
    return p;
  endfunction

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [CNT_W-1:0] cnt_exp;
    cnt_exp = n_acc[CNT_W-1:0];
    check("in_ready1", in_ready1, q1.size() < 2);
    check("in_ready8", in_ready8, q8.size() < 2);
    check("out_valid1", out_valid1, q1.size() > 0);
    check("out_valid8", out_valid8, q8.size() > 0);
    check("accepted1", accepted1, cnt_exp);
    check("accepted8", accepted8, cnt_exp);
    if (q1.size() > 0) check("out1_head", out1, q1[0]);
    if (q8.size() > 0) check("out8_head", out8, q8[0]);
  endtask

  // One clock: apply inputs at the falling edge, check current state, advance model.
  task automatic step(input logic iv, input int m, input int av, input logic ordy);
    logic do_push, do_pop;
    logic [OUT_W-1:0] p1, p8;
    in_valid  = iv;
    mode      = m[1:0];
    a8        = av[7:0];
    a1        = av[0:0];
    out_ready = ordy;
    check_state();
    do_push = iv && (q1.size() < 2);
    do_pop  = ordy && (q1.size() > 0);
    if (do_pop) begin
      void'(q1.pop_front());
      void'(q8.pop_front());
    end
    if (do_push) begin
      p1 = model_pat(1, m, av & 1, acc1);
      p8 = model_pat(8, m, av & 255, acc8);
      if (m == 3) begin
        acc1 = p1;
        acc8 = p8;
      end
      q1.push_back(p1);
      q8.push_back(p8);
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    mode      = 2'd3;
    a8        = 8'd1;
    a1        = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    q1.delete();
    q8.delete();
    acc1  = '0;
    acc8  = '0;
    n_acc = 0;
    check("rst_out_valid1", out_valid1, 1'b0);
    check("rst_in_ready1", in_ready1, 1'b1);
    check("rst_out1", out1, '0);
    check("rst_out8", out8, '0);
    check("rst_accepted1", accepted1, '0);
    check("rst_accepted8", accepted8, '0);
  endtask

  initial begin
    int base;
    logic [OUT_W-1:0] stripe1;
    stripe1 = {64{2'b01}};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode = 2'd0;
    a8 = '0;
    a1 = '0;
    @(negedge clk);
    do_reset();

    // Legacy behaviour and 1-cycle latency.
    step(1'b1, 0, 0, 1'b1);
    check("legacy_a0_valid", out_valid1, 1'b1);
    check("legacy_a0", out1, '0);
    step(1'b1, 0, 1, 1'b1);
    check("legacy_a1", out1, stripe1);

    // One-hot and thermometer edges on the 8-bit select instance.
    step(1'b1, 1, 5, 1'b1);
    check("onehot5", out8, 128'h20);
    step(1'b1, 1, 200, 1'b1);
    check("onehot200", out8, '0);
    step(1'b1, 2, 4, 1'b1);
    check("therm4", out8, 128'hF);
    step(1'b1, 2, 200, 1'b1);
    check("therm200", out8, '1);

    // Accumulator; a STRIPE request in between must not disturb it.
    step(1'b1, 3, 1, 1'b1);
    check("xacc_first", out1, stripe1);
    step(1'b1, 3, 1, 1'b1);
    check("xacc_second", out1, '0);
    step(1'b1, 0, 1, 1'b1);
    step(1'b1, 3, 0, 1'b1);
    check("xacc_after_stripe", out1, '0);
    step(1'b0, 0, 0, 1'b1);

    // Backpressure: four distinct requests offered, only two taken.
    base = n_acc;
    for (int k = 0; k < 4; k++) step(1'b1, 2, 10 + k, 1'b0);
    check("bp_in_ready", in_ready8, 1'b0);
    check("bp_accepted", accepted8, CNT_W'(base + 2));
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b1);

    // Occupancy 1 with push and pop every cycle.
    step(1'b1, 2, 20, 1'b0);
    base = n_acc;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1, 30 + k, 1'b1);
      check("occ1_valid", out_valid8, 1'b1);
    end
    check("occ1_accepted", accepted8, CNT_W'(base + 10));
    step(1'b0, 0, 0, 1'b1);

    // Randomised traffic.
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 255),
           $urandom_range(0, 2) != 0);

    // Reset with a full buffer and nonzero accumulator.
    do_reset();
    step(1'b1, 3, 1, 1'b0);
    step(1'b1, 2, 7, 1'b0);
    check("pre_rst_full", in_ready1, 1'b0);
    do_reset();
    check("rst_in_ready8", in_ready8, 1'b1);
    check("rst_out_valid8", out_valid8, 1'b0);
    step(1'b1, 3, 1, 1'b1);
    check("xacc_after_rst", out1, stripe1);
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
